// File: rtl/sev_seg_pkg.sv
// Shared types and helpers for the seven-segment scan display: FSM states,
// segment patterns (bit6 = a ... bit0 = g, active high) and BCD sizing.
package sev_seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] seg_enc(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'h7E;
            4'h1: pat = 7'h30;
            4'h2: pat = 7'h6D;
            4'h3: pat = 7'h79;
            4'h4: pat = 7'h33;
            4'h5: pat = 7'h5B;
            4'h6: pat = 7'h5F;
            4'h7: pat = 7'h70;
            4'h8: pat = 7'h7F;
            4'h9: pat = 7'h7B;
            4'hA: pat = 7'h77;
            4'hB: pat = 7'h1F;
            4'hC: pat = 7'h4E;
            4'hD: pat = 7'h3D;
            4'hE: pat = 7'h4F;
            default: pat = 7'h47;
        endcase
        return pat;
    endfunction

    // ceil(w * log10(2)) in fixed point; 10 digits for a 32-bit value.
    function automatic int bcd_digits(input int w);
        return (w * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bcd_seq_conv.sv
// Sequential double-dabble: start loads bin and performs the first shift, done pulses
// the cycle after the DATA_W-th shift; bcd holds its result until the next start.
module bcd_seq_conv
    import sev_seg_pkg::*;
#(
    parameter int  DATA_W = 32,
    localparam int BCD_W  = 4 * bcd_digits(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] bin,
    output logic              done,
    output logic [BCD_W-1:0]  bcd
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] r_sh;
    logic [BCD_W-1:0]  r_bcd;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic              r_done;
    logic [BCD_W-1:0]  w_adj;

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // The start edge doubles as the first shift: an all-zero BCD field needs no adjust.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh   <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_bcd  <= BCD_W'(bin[DATA_W-1]);
                r_sh   <= bin << 1;
                r_cnt  <= CNT_W'(DATA_W - 1);
                r_busy <= (DATA_W > 1);
                r_done <= (DATA_W == 1);
            end else if (r_busy) begin
                r_bcd <= {w_adj[BCD_W-2:0], r_sh[DATA_W-1]};
                r_sh  <= r_sh << 1;
                r_cnt <= r_cnt - 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign done = r_done;
    assign bcd  = r_bcd;

endmodule

// File: rtl/sev_seg_scan_disp.sv
// Time-multiplexed 7-segment driver: load -> display in DATA_W+1 cycles (decimal) or 1 (hex);
// load_ready stays low from accept until the display update, extra load_valid is dropped.
module sev_seg_scan_disp
    import sev_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int DATA_W         = 32,
    parameter int REFRESH_DIV    = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_W-1:0]     value_in,
    input  logic                  mode_hex,
    input  logic                  blank_lz,
    input  logic                  load_valid,
    output logic                  load_ready,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  ovf
);

    localparam int BCD_W  = 4 * bcd_digits(DATA_W);
    localparam int DISP_W = 4 * NUM_DIGITS;
    localparam int VPAD_W = (DATA_W > DISP_W) ? DATA_W : DISP_W;
    localparam int BPAD_W = (BCD_W > DISP_W) ? BCD_W : DISP_W;
    localparam int CNT_W  = $clog2(REFRESH_DIV);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

    state_t                r_state;
    logic                  r_load_ready;
    logic                  r_hex;
    logic [DATA_W-1:0]     r_val;
    logic [DISP_W-1:0]     r_digits;
    logic                  r_ovf;
    logic [CNT_W-1:0]      r_ref_cnt;
    logic [IDX_W-1:0]      r_scan_idx;
    logic [6:0]            r_seg;
    logic [NUM_DIGITS-1:0] r_an;

    logic                  w_accept;
    logic                  w_done;
    logic [BCD_W-1:0]      w_bcd;
    logic [VPAD_W-1:0]     w_val_pad;
    logic [BPAD_W-1:0]     w_bcd_pad;
    logic [NUM_DIGITS-1:0] w_lz;
    logic                  w_zero_run;
    logic [3:0]            w_cur;
    logic                  w_cur_lz;
    logic [NUM_DIGITS-1:0] w_an_hot;
    logic [6:0]            w_pat;
    logic [6:0]            w_seg_nxt;
    logic [NUM_DIGITS-1:0] w_an_nxt;
    logic [IDX_W-1:0]      w_idx_nxt;

    assign w_accept  = load_valid && r_load_ready;
    assign w_val_pad = VPAD_W'(r_val);
    assign w_bcd_pad = BPAD_W'(w_bcd);

    bcd_seq_conv #(
        .DATA_W (DATA_W)
    ) u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_accept && !mode_hex),
        .bin   (value_in),
        .done  (w_done),
        .bcd   (w_bcd)
    );

    // Display registers and ovf change only in COMMIT, so a conversion never shows partial digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_load_ready <= 1'b1;
            r_hex        <= 1'b0;
            r_val        <= '0;
            r_digits     <= '0;
            r_ovf        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_load_ready <= 1'b0;
                        r_val        <= value_in;
                        r_hex        <= mode_hex;
                        r_state      <= mode_hex ? ST_COMMIT : ST_CONV;
                    end
                end
                ST_CONV: begin
                    if (w_done) begin
                        r_state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    r_digits     <= r_hex ? w_val_pad[DISP_W-1:0] : w_bcd_pad[DISP_W-1:0];
                    r_ovf        <= r_hex ? |(w_val_pad >> DISP_W) : |(w_bcd_pad >> DISP_W);
                    r_load_ready <= 1'b1;
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_lz       = '0;
        w_zero_run = 1'b1;
        w_cur      = 4'd0;
        w_cur_lz   = 1'b0;
        w_an_hot   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zero_run = w_zero_run && (r_digits[4*i +: 4] == 4'd0);
            w_lz[i]    = w_zero_run;
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IDX_W'(i) == r_scan_idx) begin
                w_cur       = r_digits[4*i +: 4];
                w_cur_lz    = w_lz[i] && (i != 0);
                w_an_hot[i] = 1'b1;
            end
        end
        w_pat     = (blank_lz && w_cur_lz) ? SEG_BLANK : seg_enc(w_cur);
        w_seg_nxt = (SEG_ACTIVE_LOW != 0) ? ~w_pat : w_pat;
        w_an_nxt  = (AN_ACTIVE_LOW != 0) ? ~w_an_hot : w_an_hot;
        w_idx_nxt = (r_scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_scan_idx + 1'b1;
    end

    // r_scan_idx names the digit lit at the next wrap, so digit 0 is the first one shown.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ref_cnt  <= '0;
            r_scan_idx <= '0;
            r_seg      <= SEG_OFF;
            r_an       <= AN_OFF;
        end else if (r_ref_cnt == CNT_W'(REFRESH_DIV - 1)) begin
            r_ref_cnt  <= '0;
            r_scan_idx <= w_idx_nxt;
            r_seg      <= w_seg_nxt;
            r_an       <= w_an_nxt;
        end else begin
            r_ref_cnt <= r_ref_cnt + 1'b1;
        end
    end

    assign load_ready = r_load_ready;
    assign seg        = r_seg;
    assign an         = r_an;
    assign ovf        = r_ovf;

endmodule

// File: tb/tb_sev_seg_scan_disp.sv
// Directed and random loads against an arithmetic display model (digit = value / base^i mod base).
module tb_sev_seg_scan_disp;

    localparam int ND = 4;
    localparam int DW = 32;
    localparam int RD = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] value_in = '0;
    logic          mode_hex = 1'b0;
    logic          blank_lz = 1'b0;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [6:0]    seg;
    logic [ND-1:0] an;
    logic          ovf;

    int total = 0;
    int bad = 0;

    longint unsigned m_val = 0;
    bit              m_hex = 1'b0;
    longint unsigned p_val = 0;
    bit              p_hex = 1'b0;

    logic [6:0] segtab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    sev_seg_scan_disp #(
        .NUM_DIGITS     (ND),
        .DATA_W         (DW),
        .REFRESH_DIV    (RD),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value_in   (value_in),
        .mode_hex   (mode_hex),
        .blank_lz   (blank_lz),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .seg        (seg),
        .an         (an),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned base_pow(input int n);
        longint unsigned p = 1;
        for (int k = 0; k < n; k++) p = p * (m_hex ? 16 : 10);
        return p;
    endfunction

    function automatic logic exp_ovf();
        return m_val >= base_pow(ND);
    endfunction

    function automatic logic [6:0] exp_seg(input int idx);
        longint unsigned base  = m_hex ? 16 : 10;
        longint unsigned pw    = base_pow(idx);
        longint unsigned shown = m_val % base_pow(ND);
        int              dig   = int'((m_val / pw) % base);
        logic            blank = blank_lz && (idx > 0) && ((shown / pw) == 0);
        logic [6:0]      pat   = blank ? 7'h00 : segtab[dig];
        return ~pat;
    endfunction

    task automatic start_load(input logic [31:0] v, input bit hx);
        int n = 0;
        while (load_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        value_in   = v;
        mode_hex   = hx;
        load_valid = 1'b1;
        p_val      = longint'(v);
        p_hex      = hx;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        value_in   = $urandom;
        mode_hex   = 1'($urandom_range(0, 1));
    endtask

    // inj > 0 raises a competing load_valid for three cycles while load_ready is low.
    task automatic finish_load(input string tag, input int inj);
        int n = 0;
        @(negedge clk);
        check({tag, "_ovf_hold"}, ovf, exp_ovf());
        while (load_ready === 1'b0 && n < 100) begin
            n++;
            if (inj > 0 && n == inj) begin
                load_valid = 1'b1;
                value_in   = 32'd9876;
            end
            if (inj > 0 && n == inj + 3) load_valid = 1'b0;
            @(negedge clk);
        end
        check({tag, "_lat"}, n, p_hex ? 1 : DW + 1);
        m_val = p_val;
        m_hex = p_hex;
        check({tag, "_ovf"}, ovf, exp_ovf());
    endtask

    task automatic check_scan(input string tag);
        repeat (RD + 1) @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            logic [ND-1:0] want;
            int            n;
            want = ~(ND'(1) << d);
            n = 0;
            while (an !== want && n < 4 * ND * RD) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("%s_an%0d", tag, d), an, want);
            check($sformatf("%s_seg%0d", tag, d), seg, exp_seg(d));
        end
    endtask

    initial begin
        // reset state and first-lit timing
        repeat (3) @(negedge clk);
        check("rst_seg", seg, 7'h7F);
        check("rst_an", an, 4'hF);
        check("rst_ready", load_ready, 1'b1);
        check("rst_ovf", ovf, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_lit_an", an, 4'hF);
        @(negedge clk);
        check("first_an", an, 4'hE);
        check("first_seg", seg, 7'h01);
        check_scan("reset_zero");

        start_load(32'd1234, 1'b0);
        finish_load("dec1234", 0);
        check_scan("dec1234");

        start_load(32'h0000BEEF, 1'b1);
        finish_load("hexBEEF", 0);
        check_scan("hexBEEF");

        blank_lz = 1'b1;
        start_load(32'd7, 1'b0);
        finish_load("dec7", 0);
        check_scan("dec7_blank");
        blank_lz = 1'b0;
        check_scan("dec7_noblank");

        start_load(32'd12345, 1'b0);
        finish_load("dec12345", 0);
        check("ovf_set", ovf, 1'b1);
        check_scan("dec12345");
        start_load(32'd5, 1'b0);
        finish_load("dec5", 0);
        check("ovf_clr", ovf, 1'b0);
        check_scan("dec5");

        start_load(32'd1111, 1'b0);
        finish_load("ignore", 5);
        check_scan("ignore");

        // reset pulse during conversion
        start_load(32'd9999, 1'b0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", load_ready, 1'b1);
        check("midrst_seg", seg, 7'h7F);
        check("midrst_an", an, 4'hF);
        @(negedge clk);
        rst_n = 1'b1;
        m_val = 0;
        m_hex = 1'b0;
        check("midrst_ovf", ovf, 1'b0);
        check_scan("midrst_clear");
        start_load(32'd42, 1'b0);
        finish_load("dec42", 0);
        check_scan("dec42");

        for (int it = 0; it < 10; it++) begin
            logic [31:0] v;
            bit          hx;
            v        = $urandom >> $urandom_range(0, 31);
            hx       = 1'($urandom_range(0, 1));
            blank_lz = 1'($urandom_range(0, 1));
            start_load(v, hx);
            finish_load($sformatf("rnd%0d", it), 0);
            check_scan($sformatf("rnd%0d", it));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
